// File: rtl/display_scan_ctrl_if.sv
// Bundle of the scan controller's control and display signals.
// The master (environment) drives enable, the requested digit values and upd_req.
// The slave (display_scan_ctrl) returns upd_ack, the digit-mux select, the digit
// enables, the active-low segments and frame_done.
interface display_scan_ctrl_if;
  logic       enable;
  logic [3:0] val1;
  logic [3:0] val4;
  logic       upd_req;
  logic       upd_ack;
  logic       sel;
  logic       digit1_en;
  logic       digit4_en;
  logic [6:0] seg;
  logic       frame_done;

  modport master (
    output enable, val1, val4, upd_req,
    input  upd_ack, sel, digit1_en, digit4_en, seg, frame_done
  );

  modport slave (
    input  enable, val1, val4, upd_req,
    output upd_ack, sel, digit1_en, digit4_en, seg, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Two-digit multiplexed 7-segment scan controller.
// Each digit is lit for DWELL cycles per visit. With macro SCAN_BLANK_EN defined,
// an all-dark gap of BLANK cycles follows each digit; without it the digits
// alternate back to back and BLANK is ignored.
// New digit values are adopted only at a frame boundary (SHOW1 entry), so a digit
// never changes value mid-frame.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - display_scan_ctrl_if.slave: enable, val1/val4, upd_req/upd_ack,
//           sel, digit1_en, digit4_en, seg {g,f,e,d,c,b,a} active-low, frame_done
// upd_ack and frame_done are aligned with the state register; the display outputs
// follow the state by one registered cycle.
module display_scan_ctrl #(
  parameter int unsigned DWELL = 50000,
  parameter int unsigned BLANK = 500
) (
  input logic          clk,
  input logic          reset,
  display_scan_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StShow1, StBlank1, StShow4, StBlank4} state_e;

  localparam logic [15:0] DwellLast = 16'(DWELL - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [15:0] BlankLast = 16'(BLANK - 1);
  localparam state_e      FrameEndSt  = StBlank4;
  localparam logic [15:0] FrameEndCnt = BlankLast;
`else
  localparam state_e      FrameEndSt  = StShow4;
  localparam logic [15:0] FrameEndCnt = DwellLast;
`endif
  localparam bit ParamsOk = (DWELL >= 2) && (DWELL <= 65535) && (BLANK >= 1) &&
                            (BLANK <= 65535);

  state_e      state_q, state_d, out_state;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  disp1_q, disp4_q;
  logic        capture, frame_end;
  logic        sel_q, sel_d;
  logic        d1_q, d1_d, d4_q, d4_d;
  logic [6:0]  seg_q, seg_d;
  logic        ack_q, done_q;

  always_comb begin : p_param_check
    assert (ParamsOk);
  end

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0:    decode = 7'b1000000;
      4'h1:    decode = 7'b1111001;
      4'h2:    decode = 7'b0100100;
      4'h3:    decode = 7'b0110000;
      4'h4:    decode = 7'b0011001;
      4'h5:    decode = 7'b0010010;
      4'h6:    decode = 7'b0000010;
      4'h7:    decode = 7'b1111000;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0010000;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b0000011;
      4'hC:    decode = 7'b1000110;
      4'hD:    decode = 7'b0100001;
      4'hE:    decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  // Next state and dwell counter; the counter restarts at 0 on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    case (state_q)
      StIdle: begin
        state_d = StShow1;
        cnt_d   = '0;
      end
      StShow1: if (cnt_q == DwellLast) begin
`ifdef SCAN_BLANK_EN
        state_d = StBlank1;
`else
        state_d = StShow4;
`endif
        cnt_d   = '0;
      end
      StShow4: if (cnt_q == DwellLast) begin
`ifdef SCAN_BLANK_EN
        state_d = StBlank4;
`else
        state_d = StShow1;
`endif
        cnt_d   = '0;
      end
`ifdef SCAN_BLANK_EN
      StBlank1: if (cnt_q == BlankLast) begin
        state_d = StShow4;
        cnt_d   = '0;
      end
      StBlank4: if (cnt_q == BlankLast) begin
        state_d = StShow1;
        cnt_d   = '0;
      end
`endif
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    // Dropping enable wins over everything, including a pending update.
    if (!bus.enable) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  // SHOW1 is only ever entered from IDLE or the frame's last state: a frame boundary.
  assign capture   = bus.upd_req && (state_d == StShow1) && (state_q != StShow1);
  assign frame_end = (state_d == FrameEndSt) && (cnt_d == FrameEndCnt);

  // Display outputs are decoded from the current state; a low enable darkens at once.
  always_comb begin
    out_state = bus.enable ? state_q : StIdle;
    sel_d     = sel_q;
    d1_d      = 1'b0;
    d4_d      = 1'b0;
    seg_d     = 7'b1111111;
    case (out_state)
      StIdle:  sel_d = 1'b0;
      StShow1: begin
        sel_d = 1'b0;
        d1_d  = 1'b1;
        seg_d = decode(disp1_q);
      end
      StShow4: begin
        sel_d = 1'b1;
        d4_d  = 1'b1;
        seg_d = decode(disp4_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      disp1_q <= '0;
      disp4_q <= '0;
      sel_q   <= 1'b0;
      d1_q    <= 1'b0;
      d4_q    <= 1'b0;
      seg_q   <= 7'b1111111;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        disp1_q <= bus.val1;
        disp4_q <= bus.val4;
      end
      sel_q  <= sel_d;
      d1_q   <= d1_d;
      d4_q   <= d4_d;
      seg_q  <= seg_d;
      ack_q  <= capture;
      done_q <= frame_end;
    end
  end

  assign bus.upd_ack    = ack_q;
  assign bus.sel        = sel_q;
  assign bus.digit1_en  = d1_q;
  assign bus.digit4_en  = d4_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DWELL=4, BLANK=2. Works for both builds:
// the gap length follows SCAN_BLANK_EN. Expectations come from a frame-position
// model (st = index within the frame after each edge, -1 = idle).
module tb_display_scan_ctrl;
  localparam int unsigned D = 4;
  localparam int unsigned B = 2;
`ifdef SCAN_BLANK_EN
  localparam int G = B;
`else
  localparam int G = 0;
`endif
  localparam int P = 2 * D + 2 * G;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  display_scan_ctrl_if bus ();

  display_scan_ctrl #(.DWELL(D), .BLANK(B)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int st      = -1;
  logic [3:0] m1 = 4'h0;
  logic [3:0] m4 = 4'h0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0:    glyph = 7'b1000000;
      4'h3:    glyph = 7'b0110000;
      4'h8:    glyph = 7'b0000000;
      4'hA:    glyph = 7'b0001000;
      default: glyph = 7'bxxxxxxx;
    endcase
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, ".d1"}, 8'(bus.digit1_en), 8'h0);
    chk({tag, ".d4"}, 8'(bus.digit4_en), 8'h0);
    chk({tag, ".sel"}, 8'(bus.sel), 8'h0);
    chk({tag, ".seg"}, 8'(bus.seg), 8'h7f);
    chk({tag, ".ack"}, 8'(bus.upd_ack), 8'h0);
    chk({tag, ".done"}, 8'(bus.frame_done), 8'h0);
  endtask

  // One clock edge: predict from inputs held before the edge, check at the negedge.
  task automatic step(input string tag);
    int o, nst;
    logic ea, ef, e1, e4, es;
    logic [6:0] eseg;
    o = st;
    if (reset) begin
      nst = -1; ea = 0; ef = 0; o = -1; m1 = 4'h0; m4 = 4'h0;
    end else if (!bus.enable) begin
      nst = -1; ea = 0; ef = 0; o = -1;
    end else begin
      nst = (st < 0) ? 0 : (st + 1) % P;
      ea  = (nst == 0) && bus.upd_req;
      ef  = (nst == P - 1);
      if (ea) begin
        m1 = bus.val1;
        m4 = bus.val4;
      end
    end
    e1 = 0; e4 = 0; es = 0; eseg = 7'b1111111;
    if (o < 0) es = 0;
    else if (o < D) begin e1 = 1; es = 0; eseg = glyph(m1); end
    else if (o < D + G) es = 0;
    else if (o < 2 * D + G) begin e4 = 1; es = 1; eseg = glyph(m4); end
    else es = 1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".d1"}, 8'(bus.digit1_en), 8'(e1));
    chk({tag, ".d4"}, 8'(bus.digit4_en), 8'(e4));
    chk({tag, ".sel"}, 8'(bus.sel), 8'(es));
    chk({tag, ".seg"}, 8'(bus.seg), 8'(eseg));
    chk({tag, ".ack"}, 8'(bus.upd_ack), 8'(ea));
    chk({tag, ".done"}, 8'(bus.frame_done), 8'(ef));
    st = nst;
    if (ea) bus.upd_req = 1'b0;
  endtask

  // Never both digits on, whatever the scenario.
  always @(negedge clk) begin
    n_tests++;
    assert (!(bus.digit1_en && bus.digit4_en)) else begin
      n_fail++;
      $error("FAIL mutex: observed d1=%0b d4=%0b expected not both 1",
             bus.digit1_en, bus.digit4_en);
    end
  end

  initial begin
    reset       = 1'b0;
    bus.enable  = 1'b0;
    bus.upd_req = 1'b0;
    bus.val1    = 4'h0;
    bus.val4    = 4'h0;
    #2 reset = 1'b1;
    #1 check_reset_values("rst_init");
    @(negedge clk);
    step("rst_hold");
    step("rst_hold");

    // First frames: capture 3/A on SHOW1 entry, then steady scanning.
    reset       = 1'b0;
    bus.enable  = 1'b1;
    bus.val1    = 4'h3;
    bus.val4    = 4'hA;
    bus.upd_req = 1'b1;
    for (int i = 0; i < 2 * P + 1; i++) step("frame");

    // Request raised during SHOW4 is held until the next SHOW1.
    for (int i = 0; i < 2 * P && st != D + G + 1; i++) step("to_show4");
    bus.val1    = 4'h8;
    bus.upd_req = 1'b1;
    for (int i = 0; i < P + 2; i++) step("upd_mid");

    // Drop enable in SHOW1 with a request pending on the same edge; re-enable.
    for (int i = 0; i < 2 * P && st != 1; i++) step("to_show1");
    bus.enable  = 1'b0;
    bus.val1    = 4'h3;
    bus.upd_req = 1'b1;
    for (int i = 0; i < 3; i++) step("dis");
    bus.enable = 1'b1;
    for (int i = 0; i < P + 2; i++) step("reen");

    // Asynchronous reset in SHOW4: outputs clear without an edge.
    for (int i = 0; i < 2 * P && st != D + G + 1; i++) step("to_show4b");
    reset = 1'b1;
    #1 check_reset_values("rst_async");
    st = -1;
    m1 = 4'h0;
    m4 = 4'h0;
    step("rst_mid");
    step("rst_mid");
    reset = 1'b0;
    for (int i = 0; i < P + 2; i++) step("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 50000: clock cycles each digit is lit per visit; legal range 2..65535.
REQ-002 Parameter BLANK, default 500: clock cycles of all-off gap after each digit; legal range 1..65535.
REQ-003 Reset is asynchronous and active-high, with one clock: port clk is the sole clock and port reset is the asynchronous, active-high reset.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 enable  input  1  level; 1 = scanning runs, 0 = display dark.
REQ-007 val1  input  4  hex value requested for digit 1.
REQ-008 val4  input  4  hex value requested for digit 4.
REQ-009 upd_req  input  1  level request to adopt val1/val4; held until upd_ack.
REQ-010 upd_ack  output  1  one-cycle pulse: val1/val4 captured into the display registers.
REQ-011 sel  output  1  digit-mux select; 0 = digit 1, 1 = digit 4.
REQ-012 digit1_en  output  1  active-high enable for digit 1.
REQ-013 digit4_en  output  1  active-high enable for digit 4.
REQ-014 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-015 frame_done  output  1  one-cycle pulse at the end of each complete scan frame.

Function
REQ-016 FSM states: IDLE, SHOW1, BLANK1, SHOW4, BLANK4; a 16-bit dwell counter times each state.
REQ-017 IDLE -> SHOW1 on the first clk edge with enable=1; the counter loads 0 on every state entry.
REQ-018 SHOW1 -> BLANK1 and SHOW4 -> BLANK4 when the counter reaches DWELL-1, so each SHOW lasts exactly DWELL cycles.
REQ-019 BLANK1 -> SHOW4 and BLANK4 -> SHOW1 when the counter reaches BLANK-1, so each BLANK lasts exactly BLANK cycles.
REQ-020 Frame length is 2*DWELL+2*BLANK cycles; frame_done pulses in the last cycle of BLANK4.
REQ-021 In SHOW1: sel=0, digit1_en=1, digit4_en=0, seg=decode(disp1).
REQ-022 In SHOW4: sel=1, digit1_en=0, digit4_en=1, seg=decode(disp4).
REQ-023 In BLANK1, BLANK4 and IDLE: digit1_en=0, digit4_en=0, seg=7'b1111111; sel holds the value from the previous SHOW state (0 in IDLE).
REQ-024 Outputs are registered, with one cycle of latency from state entry to the matching output values.
REQ-025 Decode covers the full hex range 0-F with standard 7-segment glyphs: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, F=7'b0001110.
REQ-026 Update rule: upd_req is sampled only on the SHOW1 entry edge (frame boundary); if high, disp1<=val1, disp4<=val4 and upd_ack=1 for that cycle.
REQ-027 A digit never changes value mid-frame.
REQ-028 When upd_req is low at a boundary, nothing is captured and upd_ack stays 0.
REQ-029 Requests pending while in IDLE are serviced on the IDLE->SHOW1 edge.
REQ-030 When enable falls, the next edge enters IDLE from any state; frame_done is not pulsed and any pending request stays pending.
REQ-031 When enable is low and upd_req is high on the same edge, IDLE wins and no capture occurs.
REQ-032 At no cycle may digit1_en and digit4_en both be 1.

Reset
REQ-033 Asserting reset forces state=IDLE, counter=0, disp1=disp4=0, sel=0, digit1_en=digit4_en=0, seg=7'b1111111, upd_ack=0, frame_done=0, immediately and independent of clk.
REQ-034 Reset mid-frame abandons the frame without a frame_done pulse.
REQ-035 After reset is released, operation resumes per REQ-017.

Configuration
REQ-036 Macro SCAN_BLANK_EN selects whether the BLANK gap is built.
REQ-037 With SCAN_BLANK_EN defined, the BLANK1/BLANK4 states and the BLANK parameter are implemented as specified.
REQ-038 Without SCAN_BLANK_EN, SHOW1->SHOW4->SHOW1 directly, the frame is 2*DWELL cycles, frame_done pulses in the last SHOW4 cycle, and BLANK is ignored.

Verification (DWELL=4, BLANK=2, SCAN_BLANK_EN defined unless noted)
REQ-039 Reset, then enable=1 with val1=3, val4=A, upd_req=1 -> upd_ack pulses on SHOW1 entry; then 4 cycles digit1_en=1 with seg=7'b0110000, 2 dark, 4 cycles digit4_en=1 with seg=7'b0001000, 2 dark; frame_done pulses every 12 cycles.
REQ-040 Raise upd_req with val1=8 during SHOW4 -> no change until the next SHOW1, where seg=7'b0000000 and upd_ack pulses once.
REQ-041 Drop enable during SHOW1 cycle 2 -> next cycle all enables 0 and seg all 1; re-enable -> SHOW1 restarts at counter 0.
REQ-042 Assert reset during SHOW4 -> outputs reach reset values without a clock edge; no frame_done pulse.
REQ-043 Build without SCAN_BLANK_EN -> digit enables alternate every 4 cycles with no dark gap and frame_done every 8 cycles.
REQ-044 Throughout all scenarios, check every cycle that digit1_en and digit4_en are never both 1.
